// File: rtl/bios_ctrl_pkg.sv
// Shared definitions for the boot-ROM / cartridge read controller:
// FSM encodings, the default unmap address and the open-bus fill value.
package bios_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ROM_ADDR = 3'd1,
        ST_ROM_DATA = 3'd2,
        ST_CART_REQ = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    localparam logic [15:0] BOOT_OFF_ADDR_DEFAULT = 16'hFF50;
    localparam logic [7:0]  OPEN_BUS_FILL         = 8'hFF;
    localparam logic [15:0] BOOT_ROM_END          = 16'h0100;

    // Full 16-bit compare: 0x0100 and above always belong to the cartridge.
    function automatic logic in_boot_window(input logic [15:0] addr);
        return addr < BOOT_ROM_END;
    endfunction

endpackage

// File: rtl/bios_ctrl_timeout.sv
// Cartridge-read watchdog: counts cycles spent waiting for an ack and flags
// the edge on which CART_TIMEOUT cycles have elapsed. Saturates, never wraps.
module bios_ctrl_timeout #(
    parameter logic [7:0] CART_TIMEOUT = 8'd255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic count_i,
    output logic expired_o
);

    logic [7:0] cnt_q, cnt_d;

    // NOTE: default assignment first so every path writes cnt_d and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (count_i && cnt_q != 8'hFF) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q holds the number of completed cycles minus one on the current edge.
    assign expired_o = count_i && (({1'b0, cnt_q} + 9'd1) >= {1'b0, CART_TIMEOUT});

endmodule

// File: rtl/bios_ctrl.sv
// Boot ROM / cartridge read controller with boot-ROM unmap register.
// Define BIOS_SKIP_EN to start with the boot ROM unmapped and route all reads to the cartridge.
module bios_ctrl
    import bios_ctrl_pkg::*;
#(
    parameter logic [15:0] BOOT_OFF_ADDR = BOOT_OFF_ADDR_DEFAULT,
    parameter logic [7:0]  CART_TIMEOUT  = 8'd255
) (
    input  logic        iClock,
    input  logic        iReset_n,
    input  logic [15:0] iCpuAddr,
    input  logic [7:0]  iCpuData,
    input  logic        iCpuRd,
    input  logic        iCpuWr,
    output logic [7:0]  oCpuData,
    output logic        oCpuReady,
    output logic [7:0]  oBiosAddr,
    input  logic [7:0]  iBiosData,
    output logic [15:0] oCartAddr,
    output logic        oCartRd,
    input  logic        iCartAck,
    input  logic [7:0]  iCartData,
    output logic        oBootActive,
    output logic        oTimeout
);

`ifdef BIOS_SKIP_EN
    localparam logic BOOT_RESET_VAL = 1'b0;
    localparam logic ROM_PATH_EN    = 1'b0;
`else
    localparam logic BOOT_RESET_VAL = 1'b1;
    localparam logic ROM_PATH_EN    = 1'b1;
`endif

    state_t      state_q, state_d;
    logic [7:0]  cpu_data_q, cpu_data_d;
    logic        ready_q, ready_d;
    logic [7:0]  bios_addr_q, bios_addr_d;
    logic [15:0] cart_addr_q, cart_addr_d;
    logic        cart_rd_q, cart_rd_d;
    logic        boot_active_q, boot_active_d;
    logic        timeout_q, timeout_d;
    logic        tmr_clear, tmr_expired, rom_hit;

    assign rom_hit = ROM_PATH_EN && boot_active_q && in_boot_window(iCpuAddr);

    bios_ctrl_timeout #(
        .CART_TIMEOUT(CART_TIMEOUT)
    ) u_timeout (
        .clk      (iClock),
        .rst_n    (iReset_n),
        .clear_i  (tmr_clear),
        .count_i  (state_q == ST_CART_REQ),
        .expired_o(tmr_expired)
    );

    always_comb begin
        state_d       = state_q;
        cpu_data_d    = cpu_data_q;
        ready_d       = 1'b0;
        bios_addr_d   = bios_addr_q;
        cart_addr_d   = cart_addr_q;
        cart_rd_d     = cart_rd_q;
        boot_active_d = boot_active_q;
        timeout_d     = timeout_q;
        tmr_clear     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // A read wins over a simultaneous write; the write is discarded.
                if (iCpuRd) begin
                    if (rom_hit) begin
                        bios_addr_d = iCpuAddr[7:0];
                        state_d     = ST_ROM_ADDR;
                    end else begin
                        cart_addr_d = iCpuAddr;
                        cart_rd_d   = 1'b1;
                        tmr_clear   = 1'b1;
                        state_d     = ST_CART_REQ;
                    end
                end else if (iCpuWr) begin
                    if (iCpuAddr == BOOT_OFF_ADDR && iCpuData != 8'h00) begin
                        boot_active_d = 1'b0;
                    end
                    state_d = ST_DONE;
                end
            end
            ST_ROM_ADDR: state_d = ST_ROM_DATA;
            ST_ROM_DATA: begin
                cpu_data_d = iBiosData;
                ready_d    = 1'b1;
                state_d    = ST_IDLE;
            end
            ST_CART_REQ: begin
                // Ack has priority over an expiring timer on the same edge.
                if (iCartAck) begin
                    cpu_data_d = iCartData;
                    cart_rd_d  = 1'b0;
                    state_d    = ST_DONE;
                end else if (tmr_expired) begin
                    cpu_data_d = OPEN_BUS_FILL;
                    timeout_d  = 1'b1;
                    cart_rd_d  = 1'b0;
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                ready_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            state_q       <= ST_IDLE;
            cpu_data_q    <= 8'h00;
            ready_q       <= 1'b0;
            bios_addr_q   <= 8'h00;
            cart_addr_q   <= 16'h0000;
            cart_rd_q     <= 1'b0;
            boot_active_q <= BOOT_RESET_VAL;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cpu_data_q    <= cpu_data_d;
            ready_q       <= ready_d;
            bios_addr_q   <= bios_addr_d;
            cart_addr_q   <= cart_addr_d;
            cart_rd_q     <= cart_rd_d;
            boot_active_q <= boot_active_d;
            timeout_q     <= timeout_d;
        end
    end

    assign oCpuData    = cpu_data_q;
    assign oCpuReady   = ready_q;
    assign oBiosAddr   = bios_addr_q;
    assign oCartAddr   = cart_addr_q;
    assign oCartRd     = cart_rd_q;
    assign oBootActive = boot_active_q;
    assign oTimeout    = timeout_q;

endmodule

// File: tb/tb_bios_ctrl.sv
// Directed testbench for bios_ctrl with a one-cycle-latency boot ROM model.
// Build with BIOS_SKIP_EN defined to exercise the skip-boot configuration.
module tb_bios_ctrl;

    logic        iClock = 1'b0;
    logic        iReset_n = 1'b0;
    logic [15:0] iCpuAddr = '0;
    logic [7:0]  iCpuData = '0;
    logic        iCpuRd = 1'b0;
    logic        iCpuWr = 1'b0;
    logic [7:0]  oCpuData;
    logic        oCpuReady;
    logic [7:0]  oBiosAddr;
    logic [7:0]  iBiosData = '0;
    logic [15:0] oCartAddr;
    logic        oCartRd;
    logic        iCartAck = 1'b0;
    logic [7:0]  iCartData = '0;
    logic        oBootActive;
    logic        oTimeout;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] rom [256];

    bios_ctrl dut (
        .iClock     (iClock),
        .iReset_n   (iReset_n),
        .iCpuAddr   (iCpuAddr),
        .iCpuData   (iCpuData),
        .iCpuRd     (iCpuRd),
        .iCpuWr     (iCpuWr),
        .oCpuData   (oCpuData),
        .oCpuReady  (oCpuReady),
        .oBiosAddr  (oBiosAddr),
        .iBiosData  (iBiosData),
        .oCartAddr  (oCartAddr),
        .oCartRd    (oCartRd),
        .iCartAck   (iCartAck),
        .iCartData  (iCartData),
        .oBootActive(oBootActive),
        .oTimeout   (oTimeout)
    );

    always #5 iClock = ~iClock;

    always @(posedge iClock) iBiosData <= rom[oBiosAddr];

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge iClock);
        #1;
    endtask

    task automatic accept_read(input logic [15:0] addr);
        iCpuAddr = addr;
        iCpuRd   = 1'b1;
        step();
        iCpuRd   = 1'b0;
    endtask

    task automatic accept_write(input logic [15:0] addr, input logic [7:0] data);
        iCpuAddr = addr;
        iCpuData = data;
        iCpuWr   = 1'b1;
        step();
        iCpuWr   = 1'b0;
    endtask

    task automatic wait_ready(input int budget, output int cycles);
        cycles = 0;
        while (!oCpuReady && cycles < budget) begin
            step();
            cycles++;
        end
    endtask

    task automatic count_pulses(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (oCpuReady) pulses++;
        end
    endtask

    task automatic cart_ack(input int delay, input logic [7:0] data);
        repeat (delay) step();
        iCartAck  = 1'b1;
        iCartData = data;
        step();
        iCartAck  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge iClock);
        iReset_n = 1'b0;
        @(negedge iClock);
        iReset_n = 1'b1;
        #1;
    endtask

    int lat;
    int pulses;

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 8'(i) ^ 8'h5A;
        rom[8'h00] = 8'h31;
        rom[8'h01] = 8'hFE;
        rom[8'hA8] = 8'hCE;

        repeat (3) @(posedge iClock);
        #1;
        check("rst_ready", oCpuReady, 0);
        check("rst_data", oCpuData, 8'h00);
        check("rst_bios_addr", oBiosAddr, 8'h00);
        check("rst_cart_addr", oCartAddr, 16'h0000);
        check("rst_cart_rd", oCartRd, 0);
        check("rst_timeout", oTimeout, 0);
`ifdef BIOS_SKIP_EN
        check("rst_boot", oBootActive, 0);
        @(negedge iClock);
        iReset_n = 1'b1;
        #1;

        accept_read(16'h0000);
        check("skip_cart_rd", oCartRd, 1);
        check("skip_cart_addr", oCartAddr, 16'h0000);
        check("skip_bios_addr", oBiosAddr, 8'h00);
        cart_ack(1, 8'h3C);
        check("skip_rd_drop", oCartRd, 0);
        step();
        check("skip_ready", oCpuReady, 1);
        check("skip_data", oCpuData, 8'h3C);
        accept_write(16'hFF50, 8'h01);
        wait_ready(10, lat);
        check("skip_wr_lat", lat, 1);
        check("skip_boot", oBootActive, 0);
`else
        check("rst_boot", oBootActive, 1);
        @(negedge iClock);
        iReset_n = 1'b1;
        #1;

        // Boot ROM reads
        accept_read(16'h0000);
        check("rom0_bios_addr", oBiosAddr, 8'h00);
        check("rom0_no_cart", oCartRd, 0);
        wait_ready(10, lat);
        check("rom0_lat", lat, 2);
        check("rom0_data", oCpuData, 8'h31);
        step();
        check("rom0_pulse_end", oCpuReady, 0);

        accept_read(16'h0001);
        check("rom1_bios_addr", oBiosAddr, 8'h01);
        wait_ready(10, lat);
        check("rom1_lat", lat, 2);
        check("rom1_data", oCpuData, 8'hFE);

        // Strobe while busy must be dropped
        step();
        accept_read(16'h00A8);
        iCpuAddr = 16'h0001;
        iCpuRd   = 1'b1;
        step();
        iCpuRd   = 1'b0;
        check("busy_bios_addr", oBiosAddr, 8'hA8);
        wait_ready(10, lat);
        check("busy_lat", lat, 1);
        check("busy_data", oCpuData, 8'hCE);
        count_pulses(6, pulses);
        check("busy_pulses", pulses, 0);

        // Simultaneous read+write: read served (cart), write discarded
        iCpuAddr = 16'hFF50;
        iCpuData = 8'h01;
        iCpuRd   = 1'b1;
        iCpuWr   = 1'b1;
        step();
        iCpuRd   = 1'b0;
        iCpuWr   = 1'b0;
        check("rdwr_cart_rd", oCartRd, 1);
        check("rdwr_cart_addr", oCartAddr, 16'hFF50);
        check("rdwr_boot", oBootActive, 1);
        cart_ack(2, 8'hA5);
        wait_ready(10, lat);
        check("rdwr_lat", lat, 1);
        check("rdwr_data", oCpuData, 8'hA5);

        // Boot-off register
        step();
        accept_write(16'hFF50, 8'h00);
        check("wr00_boot", oBootActive, 1);
        wait_ready(10, lat);
        check("wr00_lat", lat, 1);
        accept_write(16'hFF51, 8'h01);
        wait_ready(10, lat);
        check("wrff51_boot", oBootActive, 1);
        accept_write(16'hFF50, 8'h01);
        check("wr01_boot", oBootActive, 0);
        wait_ready(10, lat);
        check("wr01_lat", lat, 1);

        // After unmap, low reads go to the cartridge
        accept_read(16'h0000);
        check("unmap_cart_rd", oCartRd, 1);
        check("unmap_cart_addr", oCartAddr, 16'h0000);
        cart_ack(2, 8'h5A);
        check("unmap_rd_drop", oCartRd, 0);
        check("unmap_not_ready", oCpuReady, 0);
        step();
        check("unmap_ready", oCpuReady, 1);
        check("unmap_data", oCpuData, 8'h5A);
        check("unmap_timeout", oTimeout, 0);

        // Cartridge timeout
        accept_read(16'h0150);
        check("to_cart_addr", oCartAddr, 16'h0150);
        lat = 0;
        while (oCartRd && lat < 300) begin
            step();
            lat++;
        end
        check("to_cycles", lat, 255);
        check("to_flag", oTimeout, 1);
        step();
        check("to_ready", oCpuReady, 1);
        check("to_data", oCpuData, 8'hFF);

        // Counter reload: a later read must not expire early
        accept_read(16'h0200);
        cart_ack(200, 8'h42);
        step();
        check("reload_ready", oCpuReady, 1);
        check("reload_data", oCpuData, 8'h42);
        check("reload_sticky", oTimeout, 1);

        // Ack on the timeout edge wins
        do_reset();
        check("rst2_boot", oBootActive, 1);
        check("rst2_timeout", oTimeout, 0);
        accept_read(16'h0150);
        repeat (254) step();
        check("race_rd_held", oCartRd, 1);
        iCartAck  = 1'b1;
        iCartData = 8'h77;
        step();
        iCartAck  = 1'b0;
        check("race_rd_drop", oCartRd, 0);
        check("race_timeout", oTimeout, 0);
        step();
        check("race_ready", oCpuReady, 1);
        check("race_data", oCpuData, 8'h77);

        // Reset during ROM_DATA aborts the read
        step();
        accept_read(16'h00A8);
        step();
        #2;
        iReset_n = 1'b0;
        #1;
        check("abort_ready", oCpuReady, 0);
        check("abort_data", oCpuData, 8'h00);
        check("abort_bios_addr", oBiosAddr, 8'h00);
        check("abort_boot", oBootActive, 1);
        @(negedge iClock);
        iReset_n = 1'b1;
        count_pulses(6, pulses);
        check("abort_pulses", pulses, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/bios_ctrl.md
BIOS_CTRL -- requirements
Module: bios_ctrl

Interface
REQ-001 Parameter BOOT_OFF_ADDR, default 16'hFF50: CPU write address that unmaps the boot ROM.
REQ-002 Parameter CART_TIMEOUT, default 8'd255: cycles to wait for iCartAck before forcing completion.
REQ-003 iClock  in  1  single clock; all state updates on rising edge.
REQ-004 iReset_n  in  1  asynchronous, active-low reset.
REQ-005 iCpuAddr  in  16  CPU address, sampled at request acceptance.
REQ-006 iCpuData  in  8  CPU write data, sampled at request acceptance.
REQ-007 iCpuRd / iCpuWr  in  1 each  one-cycle request strobes.
REQ-008 oCpuData  out  8  read data, valid while oCpuReady=1.
REQ-009 oCpuReady  out  1  one-cycle completion pulse.
REQ-010 oBiosAddr  out  8  registered address to the synchronous boot ROM, which has one-cycle read latency.
REQ-011 iBiosData  in  8  boot ROM read data.
REQ-012 oCartAddr  out  16 / oCartRd  out  1  cartridge read request, held until ack or timeout.
REQ-013 iCartAck  in  1 / iCartData  in  8  cartridge completion and data.
REQ-014 oBootActive  out  1  boot ROM mapped at 0x0000-0x00FF.
REQ-015 oTimeout  out  1  sticky flag: a cartridge read timed out.

Function
REQ-016 The FSM SHALL have the states IDLE, ROM_ADDR, ROM_DATA, CART_REQ and DONE.
REQ-017 Requests SHALL be accepted only in IDLE; strobes arriving in any other state are dropped, with no queuing.
REQ-018 If iCpuRd and iCpuWr are asserted together, the read SHALL be served and the write discarded.
REQ-019 A read with oBootActive=1 and iCpuAddr<16'h0100 SHALL follow this sequence:
- acceptance edge E0: oBiosAddr <= iCpuAddr[7:0], state goes to ROM_ADDR.
- edge E1: state goes to ROM_DATA.
- edge E2: oCpuData <= iBiosData, oCpuReady=1 for exactly one cycle, state returns to IDLE.
REQ-020 Any other read SHALL do the following:
- acceptance edge: oCartAddr <= iCpuAddr, oCartRd=1, enter CART_REQ.
- on the edge where iCartAck=1: capture iCartData, drop oCartRd, pulse oCpuReady on the next cycle.
REQ-021 If CART_TIMEOUT cycles elapse in CART_REQ without an ack:
- oCpuData SHALL be 8'hFF and oCpuReady SHALL pulse.
- oTimeout SHALL be set; it stays set until reset.
- oCartRd SHALL be dropped.
REQ-022 If iCartAck and the timeout occur on the same edge, the ack SHALL win and oTimeout SHALL remain unchanged.
REQ-023 A write to BOOT_OFF_ADDR with a nonzero data value SHALL clear oBootActive on the acceptance edge; the clear is irreversible until reset.
REQ-024 A write to BOOT_OFF_ADDR with data 8'h00 SHALL leave oBootActive unchanged.
REQ-025 Every accepted write SHALL pulse oCpuReady one cycle after acceptance.
REQ-026 Writes to any address other than BOOT_OFF_ADDR SHALL have no other effect.
REQ-027 A read that was accepted before oBootActive cleared SHALL complete on the path chosen at acceptance.
REQ-028 The address comparison SHALL use all 16 bits; 16'h0100 and above route to the cartridge.
REQ-029 The timeout counter SHALL be 8 bits, reload to 0 on entering CART_REQ, and never wrap.

Reset
REQ-030 While iReset_n=0, the block SHALL hold these values:
- state=IDLE.
- oCpuData=8'h00, oCpuReady=0.
- oBiosAddr=8'h00.
- oCartAddr=16'h0000, oCartRd=0.
- oTimeout=0.
- oBootActive=1, or the value set by REQ-032.
REQ-031 A reset asserted mid-transaction SHALL abort it immediately, with no oCpuReady pulse after release.

Configuration
REQ-032 With BIOS_SKIP_EN defined:
- oBootActive SHALL reset to 0.
- All reads SHALL route to the cartridge.
- Writes to BOOT_OFF_ADDR SHALL still be acknowledged.
REQ-033 Without BIOS_SKIP_EN, oBootActive SHALL reset to 1.

Structure
REQ-034 The following SHALL live in the shared pgb package/header:
- the FSM state encodings.
- the BOOT_OFF_ADDR default.
- the 8'hFF open-bus fill value.
REQ-035 The boot ROM SHALL remain an external instance; the only sub-module SHALL be bios_ctrl_timeout, the CART_TIMEOUT counter.

Verification
REQ-036 Reset release, read 16'h0000 -> oBiosAddr=8'h00, oCpuReady two edges after acceptance, oCpuData=8'h31.
REQ-037 Reads of 16'h0001 and 16'h00A8 -> oCpuData=8'hFE and 8'hCE; a strobe issued while busy -> dropped, one pulse only.
REQ-038 Write FF50=8'h00 -> oBootActive stays 1; write FF50=8'h01 -> oBootActive=0; then read 16'h0000 -> oCartRd=1 with oCartAddr=16'h0000.
REQ-039 Cartridge read of 16'h0150 with iCartAck held low -> after 255 cycles oCpuData=8'hFF, oTimeout=1; ack on the timeout edge -> iCartData returned and oTimeout=0.
REQ-040 iReset_n=0 during ROM_DATA -> no oCpuReady pulse, all outputs at reset values, oBootActive=1.
REQ-041 Build with BIOS_SKIP_EN, read 16'h0000 -> cartridge path is taken and oBootActive=0 from reset.
